// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: two request/ack ports
// (m0 = core load/store unit, m1 = loader/DMA).
interface dmem_arbiter_if #(
    parameter int ADDR_W = 17
);
    logic              m0_req;
    logic              m0_we;
    logic [1:0]        m0_size;
    logic [ADDR_W-1:0] m0_addr;
    logic [31:0]       m0_wdata;
    logic              m0_ack;
    logic              m0_err;
    logic [31:0]       m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [1:0]        m1_size;
    logic [ADDR_W-1:0] m1_addr;
    logic [31:0]       m1_wdata;
    logic              m1_ack;
    logic              m1_err;
    logic [31:0]       m1_rdata;

    modport master (
        output m0_req, m0_we, m0_size, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_size, m1_addr, m1_wdata,
        input  m0_ack, m0_err, m0_rdata,
        input  m1_ack, m1_err, m1_rdata
    );

    modport slave (
        input  m0_req, m0_we, m0_size, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_size, m1_addr, m1_wdata,
        output m0_ack, m0_err, m0_rdata,
        output m1_ack, m1_err, m1_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one word-organised data memory between two requesters,
// with read-modify-write for sub-word stores. Optional perf counters: DMEM_ARB_PERF_EN.
module dmem_arbiter #(
    parameter int ADDR_W        = 17,
    parameter bit RR_RESET_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     bus,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_writeData,
    output logic              mem_writeEnable,
    input  logic [31:0]       mem_readData,
    output logic [31:0]       perf_cnt0,
    output logic [31:0]       perf_cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        XFER = 2'b01,
        WR2  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;

    logic              r_gnt;
    logic              r_last_gnt;
    logic              r_we;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_merge;
    logic              r_ack0, r_ack1, r_err0, r_err1;
    logic [31:0]       r_rdata0, r_rdata1;

    logic              w_any_req;
    logic              w_win;
    logic              w_sel_we;
    logic [1:0]        w_sel_size;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic              w_sel_err;
    logic              w_ack_set;
    logic              w_ack_gnt;
    logic              w_ack_err;
    logic              w_we_raw;

    function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = lo[0];
            2'b10:   bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [1:0] size, input logic [1:0] lo);
        logic [31:0] res;
        res = old;
        case (size)
            2'b00:   res[{lo, 3'b000} +: 8] = wd[7:0];
            2'b01:   res[{lo[1], 4'b0000} +: 16] = wd[15:0];
            default: res = old;
        endcase
        return res;
    endfunction

    // Winner selection: a lone request wins, contention goes to the port not granted last.
    always_comb begin
        w_any_req = bus.m0_req | bus.m1_req;
        if (bus.m0_req && bus.m1_req) begin
            w_win = ~r_last_gnt;
        end else begin
            w_win = bus.m1_req;
        end
        if (w_win) begin
            w_sel_we    = bus.m1_we;
            w_sel_size  = bus.m1_size;
            w_sel_addr  = bus.m1_addr;
            w_sel_wdata = bus.m1_wdata;
        end else begin
            w_sel_we    = bus.m0_we;
            w_sel_size  = bus.m0_size;
            w_sel_addr  = bus.m0_addr;
            w_sel_wdata = bus.m0_wdata;
        end
        w_sel_err = f_misaligned(w_sel_size, w_sel_addr[1:0]);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and memory-side outputs.
    always_comb begin
        w_state_nx    = r_state;
        mem_address   = {ADDR_W{1'b0}};
        mem_writeData = 32'h0;
        w_we_raw      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_state_nx = w_sel_err ? DONE : XFER;
                end else begin
                    w_state_nx = IDLE;
                end
            end
            XFER: begin
                mem_address = r_addr;
                if (!r_we) begin
                    w_state_nx = DONE;
                end else if (r_size == 2'b10) begin
                    w_we_raw      = 1'b1;
                    mem_writeData = r_wdata;
                    w_state_nx    = DONE;
                end else begin
                    w_state_nx = WR2;
                end
            end
            WR2: begin
                mem_address   = r_addr;
                w_we_raw      = 1'b1;
                mem_writeData = r_merge;
                w_state_nx    = DONE;
            end
            DONE: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // A write can never commit on an edge where reset is asserted.
    assign mem_writeEnable = w_we_raw & rst_n;

    // Completion: errors ack straight from IDLE, everything else once it reaches DONE.
    always_comb begin
        w_ack_set = 1'b0;
        w_ack_gnt = r_gnt;
        w_ack_err = 1'b0;
        case (r_state)
            IDLE: begin
                w_ack_set = w_any_req & w_sel_err;
                w_ack_gnt = w_win;
                w_ack_err = w_sel_err;
            end
            XFER:    w_ack_set = (w_state_nx == DONE);
            WR2:     w_ack_set = 1'b1;
            default: w_ack_set = 1'b0;
        endcase
    end

    // Transaction latch, RMW merge, read capture and registered requester outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gnt      <= 1'b0;
            r_last_gnt <= ~RR_RESET_PRIO;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_addr     <= {ADDR_W{1'b0}};
            r_wdata    <= 32'h0;
            r_merge    <= 32'h0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_err0     <= 1'b0;
            r_err1     <= 1'b0;
            r_rdata0   <= 32'h0;
            r_rdata1   <= 32'h0;
        end else begin
            r_ack0 <= w_ack_set & ~w_ack_gnt;
            r_ack1 <= w_ack_set & w_ack_gnt;
            r_err0 <= w_ack_set & ~w_ack_gnt & w_ack_err;
            r_err1 <= w_ack_set & w_ack_gnt & w_ack_err;
            if ((r_state == IDLE) && w_any_req) begin
                r_gnt      <= w_win;
                r_last_gnt <= w_win;
                r_we       <= w_sel_we;
                r_size     <= w_sel_size;
                r_addr     <= w_sel_addr;
                r_wdata    <= w_sel_wdata;
                if (w_sel_err && !w_win) begin
                    r_rdata0 <= 32'h0;
                end else if (w_sel_err && w_win) begin
                    r_rdata1 <= 32'h0;
                end
            end else if (r_state == XFER) begin
                if (!r_we && !r_gnt) begin
                    r_rdata0 <= mem_readData;
                end else if (!r_we && r_gnt) begin
                    r_rdata1 <= mem_readData;
                end
                r_merge <= f_merge(mem_readData, r_wdata, r_size, r_addr[1:0]);
            end
        end
    end

    assign bus.m0_ack   = r_ack0;
    assign bus.m1_ack   = r_ack1;
    assign bus.m0_err   = r_err0;
    assign bus.m1_err   = r_err1;
    assign bus.m0_rdata = r_rdata0;
    assign bus.m1_rdata = r_rdata1;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] r_perf0, r_perf1;

    // Completed-transaction counters, errored acks included; wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf0 <= 32'h0;
            r_perf1 <= 32'h0;
        end else begin
            r_perf0 <= r_perf0 + {31'h0, r_ack0};
            r_perf1 <= r_perf1 + {31'h0, r_ack1};
        end
    end

    assign perf_cnt0 = r_perf0;
    assign perf_cnt1 = r_perf1;
`else
    assign perf_cnt0 = 32'h0;
    assign perf_cnt1 = 32'h0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table plus contention and mid-transaction reset sequences,
// checked through an expected-result queue against a behavioural word memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [16:0] mem_address;
    logic [31:0] mem_writeData;
    logic        mem_writeEnable;
    logic [31:0] mem_readData;
    logic [31:0] perf_cnt0, perf_cnt1;

    dmem_arbiter_if #(.ADDR_W(17)) bus ();

    dmem_arbiter #(.ADDR_W(17), .RR_RESET_PRIO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .mem_address(mem_address), .mem_writeData(mem_writeData),
        .mem_writeEnable(mem_writeEnable), .mem_readData(mem_readData),
        .perf_cnt0(perf_cnt0), .perf_cnt1(perf_cnt1)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:32767];
    logic        pl_en = 1'b0;
    logic [16:0] pl_addr = 17'h0;
    logic [31:0] pl_data = 32'h0;
    int          wcnt = 0;
    logic [31:0] wlast = 32'h0;
    int          cyc = 0;

    assign mem_readData = mem[mem_address[16:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_writeEnable) begin
            mem[mem_address[16:2]] <= mem_writeData;
            wcnt  <= wcnt + 1;
            wlast <= mem_writeData;
        end else if (pl_en) begin
            mem[pl_addr[16:2]] <= pl_data;
        end
    end

    typedef struct {
        bit          port;
        bit          we;
        logic [1:0]  size;
        logic [16:0] addr;
        logic [31:0] wdata;
        bit          pre_en;
        logic [31:0] pre_data;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          lat;
        int          exp_wcnt;
        logic [31:0] exp_wdata;
        logic [31:0] exp_post;
    } vec_t;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        bit          err;
        bit          chk_rd;
        int          issue;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   exp_perf0 = 0;
    int   exp_perf1 = 0;
    int   last_ack = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [16:0] addr, input logic [31:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = addr; pl_data = data;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic clear_reqs();
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    endtask

    task automatic drive(input bit port, input bit we, input logic [1:0] size,
                         input logic [16:0] addr, input logic [31:0] wdata);
        if (!port) begin
            bus.m0_we = we; bus.m0_size = size; bus.m0_addr = addr; bus.m0_wdata = wdata;
            bus.m0_req = 1'b1;
        end else begin
            bus.m1_we = we; bus.m1_size = size; bus.m1_addr = addr; bus.m1_wdata = wdata;
            bus.m1_req = 1'b1;
        end
    endtask

    task automatic check_perf(input string name);
`ifdef DMEM_ARB_PERF_EN
        check32({name, "_perf0"}, perf_cnt0, exp_perf0);
        check32({name, "_perf1"}, perf_cnt1, exp_perf1);
`else
        check32({name, "_perf0"}, perf_cnt0, 32'h0);
        check32({name, "_perf1"}, perf_cnt1, 32'h0);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_reqs();
        repeat (2) @(negedge clk);
        exp_perf0 = 0; exp_perf1 = 0;
        check32("rst_ack", {30'h0, bus.m1_ack, bus.m0_ack}, 32'h0);
        check32("rst_err", {30'h0, bus.m1_err, bus.m0_err}, 32'h0);
        check32("rst_rdata0", bus.m0_rdata, 32'h0);
        check32("rst_rdata1", bus.m1_rdata, 32'h0);
        check32("rst_mem_addr", {15'h0, mem_address}, 32'h0);
        check32("rst_mem_we", {31'h0, mem_writeEnable}, 32'h0);
        check_perf("rst");
        rst_n = 1'b1;
    endtask

    // Pops one expected record per ack; hold keeps requests asserted across acks.
    task automatic service(input int budget, input bit hold);
        int   n;
        bit   p;
        exp_t e;
        n = 0;
        while (sbq.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
            if (bus.m0_ack && bus.m1_ack) begin
                check32("dual_ack", 32'h1, 32'h0);
            end else if (bus.m0_ack || bus.m1_ack) begin
                p = bus.m1_ack;
                e = sbq.pop_front();
                check32("ack_port", {31'h0, p}, {31'h0, e.port});
                if (e.chk_rd) check32("rdata", p ? bus.m1_rdata : bus.m0_rdata, e.rdata);
                check32("err", {31'h0, p ? bus.m1_err : bus.m0_err}, {31'h0, e.err});
                if (e.issue >= 0) check32("latency", cyc - e.issue, e.lat - 1);
                else              check32("ack_gap", cyc - last_ack, 3);
                last_ack = cyc;
                if (e.port) exp_perf1++; else exp_perf0++;
                if (!hold) begin
                    if (p) bus.m1_req = 1'b0; else bus.m0_req = 1'b0;
                end
            end
        end
        if (sbq.size() > 0) begin
            checks++; failures++;
            $display("FAIL ack_timeout: %0d acks outstanding, expected 0", sbq.size());
            sbq.delete();
        end
        if (hold) clear_reqs();
    endtask

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        exp_t e;
        //            port we  size   addr      wdata         pre  pre_data      rdata         err lat wc wdata         post
        vecs[0]  = '{1'b0,1'b0,2'b10,17'h00010,32'h0,        1'b1,32'hDEADBEEF,32'hDEADBEEF,1'b0,3,0,32'h0,        32'hDEADBEEF};
        vecs[1]  = '{1'b1,1'b1,2'b00,17'h00012,32'h000000AB, 1'b1,32'h11223344,32'h0,       1'b0,4,1,32'h11AB3344,32'h11AB3344};
        vecs[2]  = '{1'b1,1'b0,2'b10,17'h00010,32'h0,        1'b0,32'h0,       32'h11AB3344,1'b0,3,0,32'h0,        32'h11AB3344};
        vecs[3]  = '{1'b0,1'b1,2'b01,17'h00016,32'h1234BEEF, 1'b1,32'hCAFEF00D,32'h0,       1'b0,4,1,32'hBEEFF00D,32'hBEEFF00D};
        vecs[4]  = '{1'b0,1'b1,2'b01,17'h00005,32'h00001234, 1'b1,32'hA5A5A5A5,32'h0,       1'b1,2,0,32'h0,        32'hA5A5A5A5};
        vecs[5]  = '{1'b1,1'b1,2'b10,17'h00020,32'h0BADCAFE, 1'b1,32'h0,       32'h0,       1'b0,3,1,32'h0BADCAFE,32'h0BADCAFE};
        vecs[6]  = '{1'b0,1'b0,2'b11,17'h00024,32'h0,        1'b1,32'h77777777,32'h0,       1'b1,2,0,32'h0,        32'h77777777};
        vecs[7]  = '{1'b1,1'b1,2'b10,17'h0002A,32'hFFFFFFFF, 1'b0,32'h0,       32'h0,       1'b1,2,0,32'h0,        32'h00000000};
        vecs[8]  = '{1'b0,1'b1,2'b00,17'h00023,32'hFFFFFF5A, 1'b0,32'h0,       32'h0,       1'b0,4,1,32'h5AADCAFE,32'h5AADCAFE};
        vecs[9]  = '{1'b0,1'b0,2'b10,17'h1FFFC,32'h0,        1'b1,32'hDA7A0001,32'hDA7A0001,1'b0,3,0,32'h0,        32'hDA7A0001};
        vecs[10] = '{1'b1,1'b1,2'b01,17'h1FFFC,32'h00009876, 1'b0,32'h0,       32'h0,       1'b0,4,1,32'hDA7A9876,32'hDA7A9876};
        vecs[11] = '{1'b0,1'b1,2'b00,17'h00000,32'h00000011, 1'b1,32'hFFFFFFFF,32'h0,       1'b0,4,1,32'hFFFFFF11,32'hFFFFFF11};

        clear_reqs();
        bus.m0_we = 1'b0; bus.m0_size = 2'b00; bus.m0_addr = 17'h0; bus.m0_wdata = 32'h0;
        bus.m1_we = 1'b0; bus.m1_size = 2'b00; bus.m1_addr = 17'h0; bus.m1_wdata = 32'h0;
        preload(17'h00028, 32'h0);
        do_reset();

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].pre_en) preload({vecs[i].addr[16:2], 2'b00}, vecs[i].pre_data);
            @(negedge clk);
            w0 = wcnt;
            e = '{vecs[i].port, vecs[i].exp_rdata, vecs[i].exp_err,
                  (!vecs[i].we) || vecs[i].exp_err, cyc, vecs[i].lat};
            sbq.push_back(e);
            drive(vecs[i].port, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata);
            service(12, 1'b0);
            check32($sformatf("v%0d_wcnt", i), wcnt - w0, vecs[i].exp_wcnt);
            if (vecs[i].exp_wcnt > 0) check32($sformatf("v%0d_wdata", i), wlast, vecs[i].exp_wdata);
            check32($sformatf("v%0d_mem", i), mem[vecs[i].addr[16:2]], vecs[i].exp_post);
        end
        @(negedge clk);
        check_perf("table");

        // Both ports hold word loads from reset: grants alternate m0, m1, m0, m1.
        do_reset();
        @(negedge clk);
        sbq.push_back('{1'b0, 32'h11AB3344, 1'b0, 1'b1, cyc, 3});
        sbq.push_back('{1'b1, 32'hBEEFF00D, 1'b0, 1'b1, -1, 3});
        sbq.push_back('{1'b0, 32'h11AB3344, 1'b0, 1'b1, -1, 3});
        sbq.push_back('{1'b1, 32'hBEEFF00D, 1'b0, 1'b1, -1, 3});
        drive(1'b0, 1'b0, 2'b10, 17'h00010, 32'h0);
        drive(1'b1, 1'b0, 2'b10, 17'h00014, 32'h0);
        service(30, 1'b1);
        @(negedge clk);
        check_perf("rr");

        // Reset lands on the XFER cycle of a byte RMW: nothing written, nothing acked.
        do_reset();
        preload(17'h00020, 32'h55667788);
        @(negedge clk);
        w0 = wcnt;
        drive(1'b1, 1'b1, 2'b00, 17'h00020, 32'h000000EE);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        clear_reqs();
        rst_n = 1'b1;
        check32("rmw_rst_addr", {15'h0, mem_address}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check32("rmw_rst_noack", {30'h0, bus.m1_ack, bus.m0_ack}, 32'h0);
        end
        check32("rmw_rst_wcnt", wcnt - w0, 32'h0);
        check32("rmw_rst_mem", mem[17'h00020 >> 2], 32'h55667788);
        exp_perf0 = 0; exp_perf1 = 0;
        sbq.push_back('{1'b0, 32'h55667788, 1'b0, 1'b1, cyc, 3});
        drive(1'b0, 1'b0, 2'b10, 17'h00020, 32'h0);
        service(12, 1'b0);
        @(negedge clk);
        check_perf("rmw_rst");

        // Reset during a word store's write cycle must gate the write enable.
        @(negedge clk);
        w0 = wcnt;
        drive(1'b0, 1'b1, 2'b10, 17'h00024, 32'h12345678);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check32("wr_rst_we", {31'h0, mem_writeEnable}, 32'h0);
        @(negedge clk);
        clear_reqs();
        rst_n = 1'b1;
        @(negedge clk);
        check32("wr_rst_wcnt", wcnt - w0, 32'h0);
        check32("wr_rst_mem", mem[17'h00024 >> 2], 32'h77777777);
        check32("wr_rst_ack", {30'h0, bus.m1_ack, bus.m0_ack}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port word-organised data memory (17-bit byte address, combinational read, write on clk posedge) between two requesters.
  - Port 0: core load/store unit.
  - Port 1: loader/DMA.
- Round-robin arbitration, one transaction at a time.
- Sub-word (byte/half) stores are done as read-modify-write, because the memory has no byte enables.
- Sits between the requesters and the data memory instance.

Parameters:
- ADDR_W, 17, byte-address width; word index is addr[ADDR_W-1:2].
- RR_RESET_PRIO, 0, port that wins the first contended arbitration after reset (0 or 1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- m0_req, m1_req  in  1  request; held high with fields stable until ack.
- m0_we, m1_we  in  1  1 = store, 0 = load.
- m0_size, m1_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- m0_addr, m1_addr  in  ADDR_W  byte address.
- m0_wdata, m1_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- m0_ack, m1_ack  out  1  one-cycle completion pulse.
- m0_err, m1_err  out  1  valid with ack; misaligned or illegal size.
- m0_rdata, m1_rdata  out  32  aligned memory word; valid with ack for loads.
- mem_address  out  ADDR_W  to memory address.
- mem_writeData  out  32  to memory write data.
- mem_writeEnable  out  1  to memory write enable.
- mem_readData  in  32  from memory read data.
- perf_cnt0, perf_cnt1  out  32  completed-transaction counters (see Optional Feature).

Behaviour:
- States:
  - IDLE: arbitrate.
  - XFER: memory access.
  - WR2: sub-word write-back.
  - DONE: ack cycle.
- IDLE:
  - If any req is high, latch the winner's we/size/addr/wdata and the grant id, then go to XFER.
  - Only one request: it wins.
  - Both requests: the port not granted last wins. The pointer resets so that RR_RESET_PRIO wins first.
  - The pointer updates on every grant.
- Alignment check at latch:
  - Error if size=11, half with addr[0]=1, or word with addr[1:0]!=0.
  - An errored transaction goes IDLE->DONE with err=1, no memory write, rdata=0.
- XFER (mem_address = latched addr):
  - Load: capture mem_readData into the rdata register, go to DONE.
  - Word store: mem_writeEnable=1, mem_writeData=wdata, go to DONE.
  - Sub-word store: capture mem_readData, then merge:
    - Byte: lane addr[1:0] gets wdata[7:0].
    - Half: lanes addr[1]*2 and addr[1]*2+1 get wdata[15:0].
    - Go to WR2.
- WR2: mem_writeEnable=1, mem_writeData=merged word, go to DONE.
- DONE:
  - Granted port's ack=1 for exactly this cycle; rdata/err valid; go to IDLE.
  - The requester must drop or change req at this edge. A req still high in the following IDLE is treated as a new request.
- Latency from req sampled in IDLE to ack:
  - Load / word store: 3 cycles (IDLE, XFER, DONE).
  - Sub-word store: 4 cycles.
  - Error: 2 cycles.
- Non-granted port: ack=0, rdata holds its last value, and its req is ignored until IDLE.
- Outputs outside XFER/WR2: mem_address=0, mem_writeData=0, mem_writeEnable=0.
- mem_writeEnable is ANDed combinationally with rst_n, so no write commits on an edge where rst_n=0.
- Reset (sync, any state, including mid read-modify-write):
  - State=IDLE; all acks, errs, rdata, latched fields and perf counters reset to 0; RR pointer reset.
  - The aborted transaction is never acked; a partial RMW leaves memory unmodified.
- Requests arriving in XFER/WR2/DONE wait; a req is never dropped while held.
- A write and a subsequent read to the same word by the other port are ordered by grant order (no bypass needed; the memory read is combinational).

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- Defined: perf_cnt0/perf_cnt1 increment by 1 on each m0_ack/m1_ack (errored transactions included), wrap from 0xFFFFFFFF to 0, and clear on reset.
- Undefined: both ports are tied to 32'h0 and no counter flops are built.

Test Plan:
- m0 load 0x00010 (word preloaded 0xDEADBEEF): m0_ack exactly 3 cycles after the req cycle, with m0_rdata=0xDEADBEEF and m0_err=0.
- m1 byte store 0xAB to 0x00012 over word 0x11223344: mem_writeEnable high for exactly one cycle (WR2) with data 0x11AB3344; m1_ack 4 cycles after req.
- m0 and m1 both request word loads from reset with RR_RESET_PRIO=0 and hold req: grants are m0, m1, m0, m1; each ack follows 3 cycles after its grant.
- m0 half store addr 0x00005 (misaligned): m0_ack+m0_err=1 after 2 cycles, mem_writeEnable never asserted, memory unchanged.
- rst_n low on the XFER cycle of a sub-word store to 0x00020 (word 0x55667788): no ack, mem_writeEnable stays 0, word still reads 0x55667788, state returns to IDLE.
- With DMEM_ARB_PERF_EN defined: 5 m0 and 3 m1 transactions give perf_cnt0=5, perf_cnt1=3; without it, both read 0.
